// File: rtl/omok_pkg.sv
// Shared constants, types and the direction step table for the omok win checker.
package omok_pkg;

    localparam int unsigned MAP_DIM = 10;
    localparam int unsigned COORD_W = 4;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b10;
    localparam logic [1:0] CELL_WHITE = 2'b11;

    localparam logic [1:0] DIR_HORIZ = 2'd0;
    localparam logic [1:0] DIR_VERT  = 2'd1;
    localparam logic [1:0] DIR_DIAG  = 2'd2;
    localparam logic [1:0] DIR_ANTI  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StScanPos,
        StScanNeg,
        StEval,
        StDone
    } state_e;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } step_t;

    function automatic step_t dir_step(input logic [1:0] dir);
        step_t s;
        case (dir)
            DIR_HORIZ: s = '{dr: 2'sd0, dc: 2'sd1};
            DIR_VERT:  s = '{dr: 2'sd1, dc: 2'sd0};
            DIR_DIAG:  s = '{dr: 2'sd1, dc: 2'sd1};
            DIR_ANTI:  s = '{dr: 2'sd1, dc: -2'sd1};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/omok_win_checker_cell_step.sv
// One step from (row,col) along a direction, forward or backward, with a per-axis bounds flag.
module omok_cell_step
    import omok_pkg::*;
#(
    parameter int unsigned MAP_DIM = omok_pkg::MAP_DIM
) (
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  logic [1:0]         i_dir,
    input  logic               i_neg,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col,
    output logic               o_in_range
);

    localparam logic [COORD_W-1:0] DIM_C = COORD_W'(MAP_DIM);

    step_t                     w_step;
    logic signed [COORD_W:0]   w_dr;
    logic signed [COORD_W:0]   w_dc;
    logic signed [COORD_W:0]   w_row;
    logic signed [COORD_W:0]   w_col;

    always_comb begin
        w_step = dir_step(i_dir);
        w_dr   = {{(COORD_W-1){w_step.dr[1]}}, w_step.dr};
        w_dc   = {{(COORD_W-1){w_step.dc[1]}}, w_step.dc};
        if (i_neg) begin
            w_dr = -w_dr;
            w_dc = -w_dc;
        end
        w_row = $signed({1'b0, i_row}) + w_dr;
        w_col = $signed({1'b0, i_col}) + w_dc;
        o_row = w_row[COORD_W-1:0];
        o_col = w_col[COORD_W-1:0];
        // Rows and columns are bounded separately so a row end never wraps to the next row.
        o_in_range = !w_row[COORD_W] && (w_row[COORD_W-1:0] < DIM_C) &&
                     !w_col[COORD_W] && (w_col[COORD_W-1:0] < DIM_C);
    end

endmodule

// File: rtl/omok_win_checker.sv
// Checks whether the stone at a given cell completes a line, walking four directions
// one neighbour per cycle over a snapshot of the board.
module omok_win_checker
    import omok_pkg::*;
#(
    parameter int unsigned MAP_DIM    = omok_pkg::MAP_DIM,
    parameter int unsigned WIN_LEN    = 5,
    parameter bit          EXACT_FIVE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [7:0]                   i_pos,
    input  logic [MAP_DIM*MAP_DIM*2-1:0] i_board_state,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_win,
    output logic [1:0]                   o_winner,
    output logic [1:0]                   o_win_dir,
    output logic [3:0]                   o_run_len
);

    localparam int unsigned        BOARD_W   = MAP_DIM * MAP_DIM * 2;
    localparam int unsigned        IDX_W     = $clog2(BOARD_W);
    localparam logic [7:0]         N_CELLS   = 8'(MAP_DIM * MAP_DIM);
    localparam logic [7:0]         DIM_B     = 8'(MAP_DIM);
    localparam logic [3:0]         WIN_LEN_B = 4'(WIN_LEN);

    state_e               r_state;
    state_e               w_state_next;
    logic [BOARD_W-1:0]   r_board;
    logic [7:0]           r_pos;
    logic [1:0]           r_colour;
    logic [1:0]           r_dir;
    logic [COORD_W-1:0]   r_org_row;
    logic [COORD_W-1:0]   r_org_col;
    logic [COORD_W-1:0]   r_row;
    logic [COORD_W-1:0]   r_col;
    logic [2:0]           r_pos_cnt;
    logic [2:0]           r_neg_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_win;
    logic [1:0]           r_winner;
    logic [1:0]           r_win_dir;
    logic [3:0]           r_run_len;

    logic [COORD_W-1:0]   w_step_row;
    logic [COORD_W-1:0]   w_step_col;
    logic                 w_in_range;
    logic [7:0]           w_nb_idx;
    logic [7:0]           w_nb_safe;
    logic [1:0]           w_nb_cell;
    logic                 w_match;
    logic                 w_pos_ok;
    logic [7:0]           w_org_safe;
    logic [1:0]           w_org_cell;
    logic                 w_org_valid;
    logic [3:0]           w_len;
    logic                 w_is_win;

    omok_cell_step #(
        .MAP_DIM (MAP_DIM)
    ) u_cell_step (
        .i_row      (r_row),
        .i_col      (r_col),
        .i_dir      (r_dir),
        .i_neg      (r_state == StScanNeg),
        .o_row      (w_step_row),
        .o_col      (w_step_col),
        .o_in_range (w_in_range)
    );

    // Indices are clamped so an off-board cursor or pos never selects past the board.
    assign w_nb_idx    = 8'(w_step_row) * DIM_B + 8'(w_step_col);
    assign w_nb_safe   = (w_nb_idx < N_CELLS) ? w_nb_idx : 8'd0;
    assign w_nb_cell   = r_board[IDX_W'({w_nb_safe, 1'b0}) +: 2];
    assign w_match     = w_in_range && (w_nb_cell == r_colour);

    assign w_pos_ok    = (r_pos < N_CELLS);
    assign w_org_safe  = w_pos_ok ? r_pos : 8'd0;
    assign w_org_cell  = r_board[IDX_W'({w_org_safe, 1'b0}) +: 2];
    assign w_org_valid = w_pos_ok && ((w_org_cell == CELL_BLACK) || (w_org_cell == CELL_WHITE));

    assign w_len    = 4'd1 + 4'(r_pos_cnt) + 4'(r_neg_cnt);
    assign w_is_win = EXACT_FIVE ? (w_len == WIN_LEN_B) : (w_len >= WIN_LEN_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_start) w_state_next = StLoad;
            StLoad:    w_state_next = w_org_valid ? StScanPos : StDone;
            StScanPos: if (!w_match || r_pos_cnt == 3'd3) w_state_next = StScanNeg;
            StScanNeg: if (!w_match || r_neg_cnt == 3'd3) w_state_next = StEval;
            StEval:    w_state_next = (w_is_win || r_dir == DIR_ANTI) ? StDone : StScanPos;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board   <= '0;
            r_pos     <= '0;
            r_colour  <= CELL_EMPTY;
            r_dir     <= DIR_HORIZ;
            r_org_row <= '0;
            r_org_col <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pos_cnt <= '0;
            r_neg_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_win     <= 1'b0;
            r_winner  <= '0;
            r_win_dir <= '0;
            r_run_len <= '0;
        end else begin
            r_done <= (r_state == StDone);
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_board   <= i_board_state;
                        r_pos     <= i_pos;
                        r_win     <= 1'b0;
                        r_winner  <= '0;
                        r_win_dir <= '0;
                        r_run_len <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                StLoad: begin
                    r_colour  <= w_org_cell;
                    r_org_row <= COORD_W'(r_pos / DIM_B);
                    r_org_col <= COORD_W'(r_pos % DIM_B);
                    r_row     <= COORD_W'(r_pos / DIM_B);
                    r_col     <= COORD_W'(r_pos % DIM_B);
                    r_dir     <= DIR_HORIZ;
                    r_pos_cnt <= '0;
                    r_neg_cnt <= '0;
                end
                StScanPos: begin
                    if (w_match) r_pos_cnt <= r_pos_cnt + 3'd1;
                    if (w_state_next == StScanNeg) begin
                        r_row <= r_org_row;
                        r_col <= r_org_col;
                    end else if (w_match) begin
                        r_row <= w_step_row;
                        r_col <= w_step_col;
                    end
                end
                StScanNeg: begin
                    if (w_match) begin
                        r_neg_cnt <= r_neg_cnt + 3'd1;
                        r_row     <= w_step_row;
                        r_col     <= w_step_col;
                    end
                end
                StEval: begin
                    if (w_is_win) begin
                        r_win     <= 1'b1;
                        r_winner  <= r_colour;
                        r_win_dir <= r_dir;
                        r_run_len <= w_len;
                    end else begin
                        if (w_len > r_run_len) r_run_len <= w_len;
                        r_dir     <= r_dir + 2'd1;
                        r_pos_cnt <= '0;
                        r_neg_cnt <= '0;
                        r_row     <= r_org_row;
                        r_col     <= r_org_col;
                    end
                end
                StDone:  r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_win     = r_win;
    assign o_winner  = r_winner;
    assign o_win_dir = r_win_dir;
    assign o_run_len = r_run_len;

endmodule
